psram_async_ctrl: RTL and testbench

- Parametrised controller for the asynchronous-mode cellular PSRAM that holds the synthesizer's audio sample memory.
- Replaces the fixed-timing read/write FSM with a request/ready handshake, registered address/data capture, and configurable read/write wait counts.
- Adds byte-lane write enables, write setup/hold phases and a recovery gap.
- Sits between the sample player / loader logic and the board PSRAM pins.

---
 rtl/psram_async_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_psram_async_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_async_ctrl.sv
// rtl/psram_async_ctrl.sv - request/ready controller for async-mode cellular PSRAM
module psram_async_ctrl #(
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 16,
    parameter int READ_WAIT  = 6,
    parameter int WRITE_WAIT = 6,
    parameter int RECOVERY   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    output logic                  ready,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    inout  wire  [DATA_W-1:0]     MemDB,
    output logic [ADDR_W-1:0]     MemAdr,
    output logic                  RamAdv,
    output logic                  RamClk,
    output logic                  RamCS,
    output logic                  MemOE,
    output logic                  MemWR,
    output logic                  RamLB,
    output logic                  RamUB
);

    localparam int BE_W    = DATA_W / 8;
    localparam int RW_MAX  = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int CNT_MAX = (RW_MAX > RECOVERY) ? RW_MAX : RECOVERY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_WAIT - 1);
    localparam logic [CNT_W-1:0] RC_LAST = CNT_W'((RECOVERY > 0) ? RECOVERY - 1 : 0);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        WSETUP  = 3'd2,
        WRITE   = 3'd3,
        WHOLD   = 3'd4,
        RECOVER = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_adr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_be;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_ready;
    logic                r_rvalid;
    logic                r_cs;
    logic                r_oe;
    logic                r_wr;
    logic                r_lb;
    logic                r_ub;
    logic                r_drive;

    logic                w_accept;
    logic                w_rd_done;
    logic [BE_W-1:0]     w_be;
    logic                w_lanes_on;
    logic                w_cs;
    logic                w_oe;
    logic                w_wr;
    logic                w_lb;
    logic                w_ub;
    logic                w_drive;

    // Next state, plus the pin levels that the next state calls for (registered below).
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_rd_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_accept = 1'b1;
                    w_next   = we ? WSETUP : READ;
                end
            end
            READ: begin
                if (r_cnt == RD_LAST) begin
                    w_rd_done = 1'b1;
                    w_next    = (RECOVERY == 0) ? IDLE : RECOVER;
                end
            end
            WSETUP:  w_next = WRITE;
            WRITE:   if (r_cnt == WR_LAST) w_next = WHOLD;
            WHOLD:   w_next = (RECOVERY == 0) ? IDLE : RECOVER;
            RECOVER: if (r_cnt == RC_LAST) w_next = IDLE;
            default: w_next = IDLE;
        endcase

        // Lane enables come straight from the request on the accepting edge.
        w_be       = w_accept ? be : r_be;
        w_lanes_on = |w_be;

        w_cs    = 1'b1;
        w_oe    = 1'b1;
        w_wr    = 1'b1;
        w_lb    = 1'b1;
        w_ub    = 1'b1;
        w_drive = 1'b0;
        case (w_next)
            READ: begin
                w_cs = 1'b0;
                w_oe = 1'b0;
                w_lb = 1'b0;
                w_ub = (DATA_W == 16) ? 1'b0 : 1'b1;
            end
            WSETUP, WRITE, WHOLD: begin
                // An all-zero byte mask keeps the chip deselected for the whole write.
                w_cs    = (w_next == WHOLD) ? 1'b1 : ~w_lanes_on;
                w_wr    = (w_next == WRITE) ? 1'b0 : 1'b1;
                w_lb    = ~w_be[0];
                w_ub    = (DATA_W == 16) ? ~w_be[BE_W-1] : 1'b1;
                w_drive = 1'b1;
            end
            default: begin
                w_cs = 1'b1;
            end
        endcase
    end

    // State, wait counter, request capture, read data and registered pin drivers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_adr    <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_rdata  <= '0;
            r_ready  <= 1'b1;
            r_rvalid <= 1'b0;
            r_cs     <= 1'b1;
            r_oe     <= 1'b1;
            r_wr     <= 1'b1;
            r_lb     <= 1'b1;
            r_ub     <= 1'b1;
            r_drive  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != {CNT_W{1'b1}}) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) begin
                r_adr   <= addr;
                r_wdata <= wdata;
                r_be    <= be;
            end
            if (w_rd_done) begin
                r_rdata <= MemDB;
            end
            r_rvalid <= w_rd_done;
            r_ready  <= (w_next == IDLE);
            r_cs     <= w_cs;
            r_oe     <= w_oe;
            r_wr     <= w_wr;
            r_lb     <= w_lb;
            r_ub     <= w_ub;
            r_drive  <= w_drive;
        end
    end

    assign MemDB  = r_drive ? r_wdata : {DATA_W{1'bz}};
    assign MemAdr = r_adr;
    assign RamAdv = r_cs;
    assign RamClk = 1'b0;
    assign RamCS  = r_cs;
    assign MemOE  = r_oe;
    assign MemWR  = r_wr;
    assign RamLB  = r_lb;
    assign RamUB  = r_ub;
    assign ready  = r_ready;
    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;

endmodule

// File: tb/tb_psram_async_ctrl.sv
// tb/tb_psram_async_ctrl.sv - self-checking bench for psram_async_ctrl
module tb_psram_async_ctrl;

    localparam int AW  = 23;
    localparam int DW  = 16;
    localparam int RW1 = 6;
    localparam int WW1 = 6;
    localparam int RC1 = 1;
    localparam int RW2 = 2;
    localparam int WW2 = 3;
    localparam int RC2 = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_cmd = 1'b0;
    logic          sel = 1'b0;
    logic          we_i = 1'b0;
    logic [AW-1:0] addr_i = '0;
    logic [DW-1:0] wdata_i = '0;
    logic [1:0]    be_i = '0;
    logic          probe = 1'b0;
    logic          req1, req2;
    assign req1 = req_cmd & ~sel;
    assign req2 = req_cmd & sel;

    logic          ready1, rvalid1, adv1, rclk1, cs1, oe1, wr1, lb1, ub1;
    logic [DW-1:0] rdata1;
    logic [AW-1:0] adr1;
    wire  [DW-1:0] db1;
    logic          ready2, rvalid2, adv2, rclk2, cs2, oe2, wr2, lb2, ub2;
    logic [DW-1:0] rdata2;
    logic [AW-1:0] adr2;
    wire  [DW-1:0] db2;

    psram_async_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_WAIT(RW1), .WRITE_WAIT(WW1), .RECOVERY(RC1)) u_dut1 (
        .clk(clk), .rst(rst_n), .req(req1), .we(we_i), .addr(addr_i), .wdata(wdata_i), .be(be_i),
        .ready(ready1), .rdata(rdata1), .rvalid(rvalid1), .MemDB(db1), .MemAdr(adr1),
        .RamAdv(adv1), .RamClk(rclk1), .RamCS(cs1), .MemOE(oe1), .MemWR(wr1), .RamLB(lb1), .RamUB(ub1)
    );

    psram_async_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_WAIT(RW2), .WRITE_WAIT(WW2), .RECOVERY(RC2)) u_dut2 (
        .clk(clk), .rst(rst_n), .req(req2), .we(we_i), .addr(addr_i), .wdata(wdata_i), .be(be_i),
        .ready(ready2), .rdata(rdata2), .rvalid(rvalid2), .MemDB(db2), .MemAdr(adr2),
        .RamAdv(adv2), .RamClk(rclk2), .RamCS(cs2), .MemOE(oe2), .MemWR(wr2), .RamLB(lb2), .RamUB(ub2)
    );

    // Pin-level PSRAM model shared by both controllers; the memory drives the bus only while OE is low.
    logic [DW-1:0] mem [64];
    logic [DW-1:0] exp_mem [64];
    logic          mem_init = 1'b0;
    int            cs_falls = 0;
    int            rv_total = 0;
    int            contention = 0;
    logic          cs1_q = 1'b1;

    assign db1 = !oe1 ? mem[adr1[5:0]] : (probe ? 16'hA5A5 : 16'hzzzz);
    assign db2 = !oe2 ? mem[adr2[5:0]] : 16'hzzzz;

    function automatic logic [DW-1:0] pre(input int i);
        if (i == 'h23) return 16'hBEEF;
        if (i == 'h07) return 16'hABCD;
        return 16'(i * 499 + 3087);
    endfunction

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] = pre(i);
            mem_init = 1'b1;
        end
        if (!wr1 && !cs1) begin
            if (!lb1) mem[adr1[5:0]][7:0]  = db1[7:0];
            if (!ub1) mem[adr1[5:0]][15:8] = db1[15:8];
        end
        if (!wr2 && !cs2) begin
            if (!lb2) mem[adr2[5:0]][7:0]  = db2[7:0];
            if (!ub2) mem[adr2[5:0]][15:8] = db2[15:8];
        end
        if ((!oe1 && !wr1) || (!oe2 && !wr2)) contention++;
        if (cs1_q && !cs1) cs_falls++;
        cs1_q = cs1;
        if (rvalid1) rv_total++;
    end

    logic          s_ready, s_rvalid, s_cs, s_oe, s_wr, s_lb, s_ub, s_adv, s_rclk;
    logic [DW-1:0] s_rdata, s_db;
    logic [AW-1:0] s_adr;
    assign s_ready  = sel ? ready2  : ready1;
    assign s_rvalid = sel ? rvalid2 : rvalid1;
    assign s_cs     = sel ? cs2     : cs1;
    assign s_oe     = sel ? oe2     : oe1;
    assign s_wr     = sel ? wr2     : wr1;
    assign s_lb     = sel ? lb2     : lb1;
    assign s_ub     = sel ? ub2     : ub1;
    assign s_adv    = sel ? adv2    : adv1;
    assign s_rclk   = sel ? rclk2   : rclk1;
    assign s_rdata  = sel ? rdata2  : rdata1;
    assign s_db     = sel ? db2     : db1;
    assign s_adr    = sel ? adr2    : adr1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // One access on the selected controller; expected timing comes from the access-length rules.
    task automatic do_access(input logic s, input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [1:0] b);
        int rw, ww, rc;
        int cs_lo, oe_lo, wr_lo, rv_n, rv_at, rdy_at, lane_bad, bus_bad, pin_bad, adr_bad;
        logic [DW-1:0] rd, exp_rd, prev_rdata;
        logic exp_lb, exp_ub;
        rw = s ? RW2 : RW1;
        ww = s ? WW2 : WW1;
        rc = s ? RC2 : RC1;
        cs_lo = 0; oe_lo = 0; wr_lo = 0; rv_n = 0; rv_at = 0; rdy_at = 0;
        lane_bad = 0; bus_bad = 0; pin_bad = 0; adr_bad = 0; rd = '0;
        exp_lb = w ? ~b[0] : 1'b0;
        exp_ub = w ? ~b[1] : 1'b0;
        @(negedge clk);
        sel = s;
        #1;
        chk("idle_ready", 32'(s_ready), 32'd1);
        prev_rdata = s_rdata;
        exp_rd = exp_mem[a[5:0]];
        we_i = w; addr_i = a; wdata_i = d; be_i = b; req_cmd = 1'b1;
        @(posedge clk);
        #1;
        req_cmd = 1'b0;
        we_i = 1'($urandom); addr_i = AW'($urandom); wdata_i = DW'($urandom); be_i = 2'($urandom);
        for (int n = 1; n <= 60 && rdy_at == 0; n++) begin
            @(negedge clk);
            if (!s_cs) begin
                cs_lo++;
                if (s_lb !== exp_lb || s_ub !== exp_ub) lane_bad++;
                if (s_adr !== a) adr_bad++;
            end
            if (!s_oe) oe_lo++;
            if (!s_wr) begin
                wr_lo++;
                if (s_db !== d) bus_bad++;
            end
            if (s_adv !== s_cs || s_rclk !== 1'b0) pin_bad++;
            if (s_rvalid) begin rv_n++; rv_at = n; rd = s_rdata; end
            if (s_ready) rdy_at = n;
        end
        if (!w) begin
            chk("rd_cs_low",    32'(cs_lo), 32'(rw));
            chk("rd_oe_low",    32'(oe_lo), 32'(rw));
            chk("rd_wr_low",    32'(wr_lo), 32'd0);
            chk("rd_rvalid_n",  32'(rv_n),  32'd1);
            chk("rd_rvalid_at", 32'(rv_at), 32'(rw + 1));
            chk("rd_data",      32'(rd),    32'(exp_rd));
            chk("rd_ready_at",  32'(rdy_at), 32'(rw + rc + 1));
        end else begin
            chk("wr_cs_low",    32'(cs_lo), (b != 2'b00) ? 32'(ww + 1) : 32'd0);
            chk("wr_wr_low",    32'(wr_lo), 32'(ww));
            chk("wr_oe_low",    32'(oe_lo), 32'd0);
            chk("wr_rvalid_n",  32'(rv_n),  32'd0);
            chk("wr_ready_at",  32'(rdy_at), 32'(ww + rc + 3));
            chk("wr_rdata_hold", 32'(s_rdata), 32'(prev_rdata));
            if (b[0]) exp_mem[a[5:0]][7:0]  = d[7:0];
            if (b[1]) exp_mem[a[5:0]][15:8] = d[15:8];
        end
        chk("lane_bad", 32'(lane_bad), 32'd0);
        chk("bus_bad",  32'(bus_bad),  32'd0);
        chk("pin_bad",  32'(pin_bad),  32'd0);
        chk("adr_bad",  32'(adr_bad),  32'd0);
    endtask

    typedef struct {
        logic          s;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [1:0]    b;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vt[14];
    int   gap[3];
    int   acc, cyc, last, c0, r0;
    logic rs, rwe;

    initial begin
        vt[0]  = '{1'b0, 1'b0, 23'h000123, 16'h0000, 2'b00, 16'hBEEF};
        vt[1]  = '{1'b0, 1'b1, 23'h000007, 16'h1234, 2'b10, 16'hBEEF};
        vt[2]  = '{1'b0, 1'b0, 23'h000007, 16'h0000, 2'b00, 16'h12CD};
        vt[3]  = '{1'b0, 1'b1, 23'h000007, 16'hFFFF, 2'b00, 16'h12CD};
        vt[4]  = '{1'b0, 1'b0, 23'h000007, 16'h0000, 2'b00, 16'h12CD};
        vt[5]  = '{1'b0, 1'b1, 23'h7FFFFF, 16'h55AA, 2'b11, 16'h12CD};
        vt[6]  = '{1'b0, 1'b0, 23'h7FFFFF, 16'h0000, 2'b00, 16'h55AA};
        vt[7]  = '{1'b0, 1'b1, 23'h000007, 16'h9876, 2'b01, 16'h55AA};
        vt[8]  = '{1'b0, 1'b0, 23'h000007, 16'h0000, 2'b00, 16'h1276};
        vt[9]  = '{1'b1, 1'b0, 23'h000123, 16'h0000, 2'b00, 16'hBEEF};
        vt[10] = '{1'b1, 1'b1, 23'h000007, 16'h0000, 2'b00, 16'hBEEF};
        vt[11] = '{1'b1, 1'b0, 23'h000007, 16'h0000, 2'b00, 16'h1276};
        vt[12] = '{1'b1, 1'b1, 23'h00002A, 16'hC3C3, 2'b11, 16'h1276};
        vt[13] = '{1'b1, 1'b0, 23'h00002A, 16'h0000, 2'b00, 16'hC3C3};
        for (int i = 0; i < 64; i++) exp_mem[i] = pre(i);

        // Reset held for three cycles, then idle pin levels.
        probe = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready",  32'(ready1), 32'd1);
        chk("rst_ctrl",   32'({cs1, oe1, wr1, lb1, ub1, adv1}), 32'h3F);
        chk("rst_ramclk", 32'(rclk1), 32'd0);
        chk("rst_rdata",  32'(rdata1), 32'd0);
        chk("rst_rvalid", 32'(rvalid1), 32'd0);
        chk("rst_adr",    32'(adr1), 32'd0);
        chk("rst_bus_z",  32'(db1), 32'hA5A5);
        probe = 1'b0;

        for (int i = 0; i < 14; i++) begin
            do_access(vt[i].s, vt[i].w, vt[i].a, vt[i].d, vt[i].b);
            chk("tbl_rdata", 32'(s_rdata), 32'(vt[i].exp_rdata));
        end

        // req held high across read/write/read: three accesses, recovery only between them.
        @(negedge clk);
        sel = 1'b0;
        c0 = cs_falls; r0 = rv_total; acc = 0; cyc = 0; last = 0;
        we_i = 1'b0; addr_i = 23'h21; be_i = 2'b11; wdata_i = 16'h0F0F; req_cmd = 1'b1;
        while (acc < 3 && cyc < 100) begin
            if (ready1 && req_cmd) begin
                if (acc > 0) gap[acc] = cyc - last;
                last = cyc;
                acc++;
                @(posedge clk);
                #1;
                we_i   = (acc == 1);
                addr_i = (acc == 1) ? 23'h22 : 23'h21;
                if (acc == 3) req_cmd = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        exp_mem[6'h22] = 16'h0F0F;
        repeat (20) @(negedge clk);
        chk("b2b_accesses", 32'(acc), 32'd3);
        chk("b2b_gap_rd",   32'(gap[1]), 32'(RW1 + RC1 + 1));
        chk("b2b_gap_wr",   32'(gap[2]), 32'(WW1 + RC1 + 3));
        chk("b2b_cs_falls", 32'(cs_falls - c0), 32'd3);
        chk("b2b_rvalids",  32'(rv_total - r0), 32'd2);
        chk("b2b_rdata",    32'(rdata1), 32'(exp_mem[6'h21]));
        chk("b2b_mem",      32'(mem[6'h22]), 32'h0F0F);

        // Randomized traffic against the scoreboard memory.
        for (int k = 0; k < 24; k++) begin
            rs  = ($urandom_range(0, 3) == 0);
            rwe = 1'($urandom);
            do_access(rs, rwe, AW'($urandom_range(0, 15)), DW'($urandom), 2'($urandom));
        end

        // Reset in the third cycle of a read aborts it without an rvalid.
        @(negedge clk);
        sel = 1'b0;
        r0 = rv_total;
        we_i = 1'b0; addr_i = 23'h15; req_cmd = 1'b1;
        @(posedge clk);
        #1;
        req_cmd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ctrl",  32'({cs1, oe1, adv1, wr1}), 32'hF);
        chk("arst_ready", 32'(ready1), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("arst_no_rvalid", 32'(rv_total - r0), 32'd0);
        do_access(1'b0, 1'b0, 23'h15, 16'h0000, 2'b00);

        chk("contention", 32'(contention), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

endmodule
